// File: rtl/battery_pkg.sv
// Shared types and helpers for the battery alarm path: FSM encoding, filter
// counter width and the charge-state LED pattern check.
package battery_pkg;

  localparam int unsigned PERSIST_W = 8;

  // Encoding 2'd3 is unused and decodes to NORMAL in the FSM default branch.
  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    ALARM    = 2'd1,
    SILENCED = 2'd2
  } alarmState_e;

  function automatic logic isOneHotOrZero(input logic [3:0] v);
    return (v & (v - 4'd1)) == 4'd0;
  endfunction

endpackage

// File: rtl/empty_persist_filter.sv
// Persistence filter: the filtered flag rises only after the raw flag has been
// high for PERSIST consecutive cycles, and drops with the raw flag.
module empty_persist_filter
  import battery_pkg::*;
#(
  parameter int unsigned PERSIST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam logic [PERSIST_W-1:0] Limit = PERSIST_W'(PERSIST);

  logic [PERSIST_W-1:0] cntQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      cntQ <= '0;
    end else if (!raw) begin
      cntQ <= '0;
    end else if (cntQ != Limit) begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign filt = (cntQ == Limit);

endmodule

// File: rtl/battery_alarm_controller.sv
// Alarm stage behind the battery bench: filters the empty flags, runs the
// NORMAL/ALARM/SILENCED machine and drives registered LEDs and buzzer.
module battery_alarm_controller
  import battery_pkg::*;
#(
  parameter int unsigned PERSIST   = 4,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned CNT_W     = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_emptyA,
  input  logic       is_emptyB,
  input  logic [3:0] led_state_in,
  input  logic       ack,
  output logic       alarm_ledA,
  output logic       alarm_ledB,
  output logic       buzzer,
  output logic       alarm_active,
  output logic [3:0] led_state_out
);

  localparam logic [CNT_W-1:0] PreMax = CNT_W'(BLINK_DIV - 1);

  logic        filtA, filtB;
  logic        filtPrevA, filtPrevB;
  logic        newEmpty;
  alarmState_e stateQ, stateD;
  logic [CNT_W-1:0] preQ, preD;
  logic        phaseQ, phaseD;

  empty_persist_filter #(.PERSIST(PERSIST)) uFiltA (
    .clk  (clk),
    .rst  (rst),
    .raw  (is_emptyA),
    .filt (filtA)
  );

  empty_persist_filter #(.PERSIST(PERSIST)) uFiltB (
    .clk  (clk),
    .rst  (rst),
    .raw  (is_emptyB),
    .filt (filtB)
  );

  assign newEmpty = (filtA & ~filtPrevA) | (filtB & ~filtPrevB);

  // Recovery outranks everything; a new empty event outranks acknowledge.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      NORMAL: begin
        if (newEmpty) stateD = ALARM;
      end
      ALARM: begin
        if (!filtA && !filtB)     stateD = NORMAL;
        else if (!newEmpty && ack) stateD = SILENCED;
      end
      SILENCED: begin
        if (!filtA && !filtB) stateD = NORMAL;
        else if (newEmpty)    stateD = ALARM;
      end
      default: stateD = NORMAL;
    endcase
  end

  // Entering ALARM restarts the blink with the LED on.
  always_comb begin
    preD   = '0;
    phaseD = 1'b0;
    if (stateD == ALARM) begin
      if (stateQ != ALARM) begin
        phaseD = 1'b1;
      end else if (preQ == PreMax) begin
        phaseD = ~phaseQ;
      end else begin
        preD   = preQ + 1'b1;
        phaseD = phaseQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ        <= NORMAL;
      preQ          <= '0;
      phaseQ        <= 1'b0;
      filtPrevA     <= 1'b0;
      filtPrevB     <= 1'b0;
      alarm_ledA    <= 1'b0;
      alarm_ledB    <= 1'b0;
      buzzer        <= 1'b0;
      alarm_active  <= 1'b0;
      led_state_out <= 4'b0000;
    end else begin
      stateQ    <= stateD;
      preQ      <= preD;
      phaseQ    <= phaseD;
      filtPrevA <= filtA;
      filtPrevB <= filtB;
      case (stateQ)
        ALARM: begin
          alarm_ledA   <= filtA & phaseQ;
          alarm_ledB   <= filtB & phaseQ;
          buzzer       <= phaseQ;
          alarm_active <= 1'b1;
        end
        SILENCED: begin
          alarm_ledA   <= filtA;
          alarm_ledB   <= filtB;
          buzzer       <= 1'b0;
          alarm_active <= 1'b1;
        end
        default: begin
          alarm_ledA   <= 1'b0;
          alarm_ledB   <= 1'b0;
          buzzer       <= 1'b0;
          alarm_active <= 1'b0;
        end
      endcase
      if (isOneHotOrZero(led_state_in)) led_state_out <= led_state_in;
    end
  end

endmodule
